fetch_queue: RTL
================

# fetch_queue

Instruction fetch front-end for the pipelined CPU. It sits directly upstream of the IF/ID pipeline register and replaces the bare PC, PC+4 adder and instruction-memory path with a small prefetch FIFO. It talks to a variable-latency instruction memory through a req/ack handshake and presents one `{pc+4, instruction}` pair per cycle to ID. Redirects (taken branch or jump, resolved in MEM) and hazard stalls are applied here.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; word aligned.

Ports:
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `imem_req_o` output 1: fetch request to instruction memory.
- `imem_addr_o` output 32: fetch address; bits [1:0] always 0.
- `imem_ack_i` input 1: memory returns data this cycle for the outstanding request.
- `imem_data_i` input 32: instruction word, valid when `imem_ack_i`=1.
- `redirect_i` input 1: taken branch or jump from MEM; flush and refetch.
- `redirect_pc_i` input 32: target; bits [1:0] ignored (forced to 0).
- `stall_i` input 1: ID cannot accept (load-use hazard); head is held.
- `valid_o` output 1: `instr_o`/`pcn_o` hold a real instruction.
- `instr_o` output 32: head instruction; 32'h0 (NOP) when `valid_o`=0.
- `pcn_o` output 32: head PC+4; 32'h0 when `valid_o`=0.

## Operation
- State: `fetch_pc` (32b), FIFO storage DEPTH×64 (`{pc+4, instr}`), read and write pointers of log2(DEPTH) bits, `count` of log2(DEPTH)+1 bits, `busy` (one outstanding request), `drop` (discard the pending response).
- Request FSM with states IDLE and WAIT:
  - IDLE → WAIT when `count` < DEPTH and not `redirect_i`. Entering WAIT asserts `imem_req_o` with `imem_addr_o`=`fetch_pc`.
  - In WAIT, req and addr stay stable until `imem_ack_i`. At most one request is outstanding.
  - WAIT on ack: if `drop`=0, push `{fetch_pc+4, imem_data_i}` and set `fetch_pc` to `fetch_pc+4`. Then go to IDLE.
- Space reservation: a request is only issued when `count` < DEPTH, so an ack never finds the FIFO full.
- Pop: when `valid_o`=1 and `stall_i`=0. `valid_o` = (`count` != 0).
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Redirect (highest priority):
  - Flush the FIFO: `count`=0, pointers=0.
  - Set `fetch_pc` = {`redirect_pc_i`[31:2], 2'b00}.
  - If a request is in WAIT without an ack this cycle, set `drop`=1. That request stays asserted with its old address until its ack, which is then discarded and clears `drop`.
  - If an ack coincides with the redirect, its data is discarded.
  - A redirect during `stall_i` still flushes.
- Arithmetic: `fetch_pc+4` is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Pointers wrap modulo DEPTH.

## Timing
- Reset values: `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `valid_o`=0, `instr_o`=0, `pcn_o`=0, `count`=0, `busy`=0, `drop`=0, `fetch_pc`=`RESET_PC`.
- Reset mid-request abandons the outstanding request. The memory must tolerate `imem_req_o` dropping.
- First `imem_req_o`=1 occurs in the first cycle after `rst_i` deasserts.
- Ack-to-output latency: an ack in cycle N into an empty FIFO gives `valid_o`=1 in cycle N+1.
- The next request is issued in cycle N+1 after an ack in cycle N. With a 1-cycle-ack memory, throughput is 1 instruction per 2 cycles.
- Outputs come from registered FIFO storage through the read-pointer mux only. There is no combinational path from `imem_data_i` to `instr_o`.
- Redirect in cycle N gives `valid_o`=0 in N+1. The new-target request goes out in N+1 if no request was in flight, or in the cycle after the dropped request's ack.

## Test plan
- Reset, then a memory with 1-cycle ack returning word = address: `imem_addr_o` sequence 0,4,8,…. `valid_o` first rises 2 cycles after reset release with `instr_o`=0 and `pcn_o`=4. Successive pops give `pcn_o` 4, 8, 12.
- `stall_i` held high for 10 cycles: the FIFO fills to DEPTH=4 and `imem_req_o` stays 0 while full. `instr_o` stays at the word from address 0. After release, 4 consecutive pops occur with no gaps.
- `redirect_i` with `redirect_pc_i`=32'h0000_0103 while idle: FIFO flushed, next `imem_addr_o`=32'h0000_0100, first output `pcn_o`=32'h0000_0104.
- Redirect to 32'h200 while a request to 32'h10 is outstanding (ack 3 cycles later): the 32'h10 data is never output. The next request is 32'h200, issued the cycle after that ack.
- Redirect to 32'hFFFF_FFFC, ack, then a second fetch: addresses 32'hFFFF_FFFC then 32'h0. First output `pcn_o`=0.
- Synchronous `rst_i` asserted during WAIT with 2 entries queued: the next cycle has `valid_o`=0 and `imem_req_o`=0, and after release the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: prefetch FIFO of {pc+4, instr} pairs fed by a
// single-outstanding req/ack instruction memory, with redirect flush and stall hold.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pcn_o
);

   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t        r_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_addr;
   logic          r_req;
   logic          r_drop;
   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic          w_valid;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic [31:0]   w_pc_plus4;
   logic [31:0]   w_target;
   logic [63:0]   w_head;
   logic          w_unused_pc_lsbs;

   assign w_valid    = (r_count != '0);
   assign w_accept   = (r_state == S_WAIT) && imem_ack_i;
   // A response accepted during a redirect, or flagged by drop, belongs to the old stream.
   assign w_push     = w_accept && !r_drop && !redirect_i;
   assign w_pop      = w_valid && !stall_i && !redirect_i;
   assign w_issue    = (r_state == S_IDLE) && (r_count < CNT_FULL) && !redirect_i;
   assign w_pc_plus4 = r_fetch_pc + 32'd4;
   assign w_target   = {redirect_pc_i[31:2], 2'b00};
   assign w_head     = r_mem[r_rptr];

   assign w_unused_pc_lsbs = ^redirect_pc_i[1:0];

   assign imem_req_o  = r_req;
   assign imem_addr_o = r_addr;
   assign valid_o     = w_valid;
   assign instr_o     = w_valid ? w_head[31:0]  : '0;
   assign pcn_o       = w_valid ? w_head[63:32] : '0;

   always_ff @(posedge clk_i) begin
      if (w_push && !rst_i) begin
         r_mem[r_wptr] <= {w_pc_plus4, imem_data_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_drop     <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_state <= S_WAIT;
                  r_req   <= 1'b1;
                  r_addr  <= r_fetch_pc;
               end
            end
            S_WAIT: begin
               // Request and address stay frozen until ack, even across a redirect.
               if (imem_ack_i) begin
                  r_state <= S_IDLE;
                  r_req   <= 1'b0;
                  r_drop  <= 1'b0;
               end else if (redirect_i) begin
                  r_drop  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase

         if (redirect_i) begin
            r_fetch_pc <= w_target;
         end else if (w_push) begin
            r_fetch_pc <= w_pc_plus4;
         end

         if (redirect_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
               r_count <= r_count - CNT_ONE;
            end
         end
      end
   end

endmodule
